// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             br_q;
  logic             borrow_d;
  logic             diff_c;
  logic             last_c;
  logic [CW-1:0]    cnt_q;

  // Full-subtractor cell on the current operand LSBs and running borrow.
  always_comb begin
    diff_c   = a_q[0] ^ b_q[0] ^ br_q;
    borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d    = {diff_c, res_q[WIDTH-1:1]};
    last_c   = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      D       <= '0;
      bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Operands shift right so the next bit is always at position 0.
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= borrow_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_c) begin
            D       <= res_d;
            bout    <= borrow_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 (directed + exhaustive)
// and WIDTH=8 (random), with an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, bin4, bout4, busy4, done4;
  logic [3:0] a4, b4, D4;
  logic       start8, bin8, bout8, busy8, done8;
  logic [7:0] a8, b8, D8;

  logic [4:0] q4[$];
  logic [8:0] q8[$];
  int tests = 0;
  int fails = 0;
  int bcnt4 = 0;
  int bcnt8 = 0;
  logic [4:0] prev4;
  logic [8:0] prev8;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .D(D4), .bout(bout4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .D(D8), .bout(bout8), .busy(busy8), .done(done8)
  );

  // {bout,D} is the difference reduced modulo 2^(W+1).
  function automatic logic [4:0] model4(input int x, input int y, input int c);
    int r;
    r = x - y - c;
    return 5'(((r % 32) + 32) % 32);
  endfunction

  function automatic logic [8:0] model8(input int x, input int y, input int c);
    int r;
    r = x - y - c;
    return 9'(((r % 512) + 512) % 512);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor for the WIDTH=4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt4 = 0;
    end else begin
      if (busy4) bcnt4++;
      tests++;
      if (busy4 && done4) begin
        fails++;
        $display("FAIL w4_busy_done_overlap: busy=%b done=%b", busy4, done4);
      end
      if (done4) begin
        tests++;
        if (q4.size() == 0) begin
          fails++;
          $display("FAIL w4_unexpected_done: D=%0d bout=%0d", D4, bout4);
        end else begin
          logic [4:0] e;
          e = q4.pop_front();
          if ({bout4, D4} !== e) begin
            fails++;
            $display("FAIL w4_result: got bout=%0d D=%0d expected bout=%0d D=%0d",
                     bout4, D4, e[4], e[3:0]);
          end
        end
        chk("w4_busy_len", bcnt4, 4);
        bcnt4 = 0;
      end else begin
        chk("w4_hold", int'({bout4, D4}), int'(prev4));
      end
    end
    prev4 = {bout4, D4};
  end

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt8 = 0;
    end else begin
      if (busy8) bcnt8++;
      tests++;
      if (busy8 && done8) begin
        fails++;
        $display("FAIL w8_busy_done_overlap: busy=%b done=%b", busy8, done8);
      end
      if (done8) begin
        tests++;
        if (q8.size() == 0) begin
          fails++;
          $display("FAIL w8_unexpected_done: D=%0d bout=%0d", D8, bout8);
        end else begin
          logic [8:0] e;
          e = q8.pop_front();
          if ({bout8, D8} !== e) begin
            fails++;
            $display("FAIL w8_result: got bout=%0d D=%0d expected bout=%0d D=%0d",
                     bout8, D8, e[8], e[7:0]);
          end
        end
        chk("w8_busy_len", bcnt8, 8);
        bcnt8 = 0;
      end else begin
        chk("w8_hold", int'({bout8, D8}), int'(prev8));
      end
    end
    prev8 = {bout8, D8};
  end

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic wait_idle4();
    int n = 0;
    while (busy4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy4) chk("w4_timeout", 1, 0);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy8) chk("w8_timeout", 1, 0);
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
    a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
    q4.push_back(model4(int'(ia), int'(ib), int'(ibin)));
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    wait_idle4();
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    q8.push_back(model8(int'(ia), int'(ib), int'(ibin)));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    wait_idle8();
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_D", int'(D4), 0);
    chk("reset_bout", int'(bout4), 0);
    chk("reset_busy", int'(busy4), 0);
    chk("reset_done", int'(done4), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; each op is issued in the done cycle of the previous one.
    op4(4'd7, 4'd3, 1'b0);
    chk("d_7_3_0_D", int'(D4), 4);   chk("d_7_3_0_bout", int'(bout4), 0);
    op4(4'd3, 4'd4, 1'b1);
    chk("d_3_4_1_D", int'(D4), 14);  chk("d_3_4_1_bout", int'(bout4), 1);
    op4(4'd8, 4'd8, 1'b1);
    chk("d_8_8_1_D", int'(D4), 15);  chk("d_8_8_1_bout", int'(bout4), 1);
    op4(4'd0, 4'd0, 1'b0);
    chk("d_0_0_0_D", int'(D4), 0);   chk("d_0_0_0_bout", int'(bout4), 0);
    op4(4'd9, 4'd2, 1'b0);
    chk("b2b_9_2_D", int'(D4), 7);   chk("b2b_9_2_bout", int'(bout4), 0);

    // Start re-pulsed while busy must be ignored.
    a4 = 4'd6; b4 = 4'd7; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back(model4(6, 7, 0));
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle4();
    chk("ign_D", int'(D4), 15);      chk("ign_bout", int'(bout4), 1);
    repeat (6) @(negedge clk);

    // Abort mid-RUN with reset; the pending result must never appear.
    a4 = 4'd7; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_D", int'(D4), 0);
    chk("abort_bout", int'(bout4), 0);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_done", int'(done4), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op4(4'd5, 4'd1, 1'b0);
    chk("post_abort_D", int'(D4), 4);

    // Exhaustive sweep at WIDTH=4.
    for (int i = 0; i < 512; i++) op4(4'(i >> 5), 4'(i >> 1), i[0]);

    // Random sweep at WIDTH=8.
    @(negedge clk);
    for (int i = 0; i < 200; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (4) @(negedge clk);
    chk("w4_queue_empty", q4.size(), 0);
    chk("w8_queue_empty", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
